// File: rtl/pgmap_pkg.sv
`default_nettype none
// pgmap_pkg: page-map entry layout, sequencer states, 68010 function codes
// and the rule for suppressing statistic updates.
package pgmap_pkg;

  localparam int PME_W       = 32;
  localparam int PME_VALID   = 31;
  localparam int PME_PROT_HI = 30;
  localparam int PME_PROT_LO = 25;
  localparam int PME_RSVD    = 24;
  localparam int PME_TYPE_HI = 23;
  localparam int PME_TYPE_LO = 22;
  localparam int PME_ACC     = 21;
  localparam int PME_MOD     = 20;
  localparam int PME_PFN_HI  = 19;

  localparam logic [2:0] FC_USER_DATA = 3'b001;
  localparam logic [2:0] FC_USER_PROG = 3'b010;
  localparam logic [2:0] FC_SUP_DATA  = 3'b101;
  localparam logic [2:0] FC_SUP_PROG  = 3'b110;
  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // CPU-space/MMU references, refresh/DMA program fetches and boot mode never touch statistics.
  function automatic logic stat_disable(input logic [2:0] fc,
                                        input logic       p_back,
                                        input logic       booten);
    return (fc[0] & fc[1] & ~p_back) | (fc[1] & p_back) | booten;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pgmap_stat_writeback_if.sv
`default_nettype none
// pgmap_stat_writeback_if: synchronous page-map RAM port.
// master = sequencer side, slave = RAM side.
interface pgmap_stat_writeback_if #(
  parameter int VPN_W = 11
);
  logic             pme_re;
  logic             pme_we;
  logic [VPN_W-1:0] pme_addr;
  logic [31:0]      pme_rdata;
  logic [31:0]      pme_wdata;

  modport master (output pme_re, output pme_we, output pme_addr,
                  output pme_wdata, input pme_rdata);
  modport slave  (input pme_re, input pme_we, input pme_addr,
                  input pme_wdata, output pme_rdata);
endinterface
`default_nettype wire

// File: rtl/pgmap_stat_calc.sv
`default_nettype none
// pgmap_stat_calc: combinational disable and accessed/modified update for one
// page-map entry, plus the decision whether the entry must be rewritten.
module pgmap_stat_calc (
  input  logic [2:0] fc,
  input  logic       p_back,
  input  logic       booten,
  input  logic       dis_q,
  input  logic       read,
  input  logic       valid,
  input  logic       acc,
  input  logic       mod,
  output logic       dis,
  output logic       acc_n,
  output logic       mod_n,
  output logic       wr_need,
  output logic       invalid
);
  import pgmap_pkg::*;

  // dis feeds the capture register; the update itself uses the captured dis_q.
  always_comb begin
    dis     = stat_disable(fc, p_back, booten);
    acc_n   = acc | (valid & ~dis_q);
    mod_n   = mod | (valid & ~dis_q & ~read);
    wr_need = (acc_n != acc) | (mod_n != mod);
    invalid = ~valid & ~dis_q;
  end

endmodule
`default_nettype wire

// File: rtl/pgmap_stat_writeback.sv
`default_nettype none
// pgmap_stat_writeback: per bus cycle, reads the page-map entry, sets
// accessed/modified and writes the entry back only when those bits change.
module pgmap_stat_writeback #(
  parameter int VPN_W  = 11,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cyc_start,
  input  logic                    cyc_read,
  input  logic [2:0]              cyc_fc,
  input  logic [VPN_W-1:0]        cyc_vpn,
  input  logic                    p_back,
  input  logic                    booten,
  pgmap_stat_writeback_if.master  ram,
  output logic                    cyc_done,
  output logic                    pme_invalid,
  output logic                    stat_dis,
  output logic [1:0]              stat_type,
  output logic                    stat_acc,
  output logic                    stat_mod,
  output logic [CNT_W-1:0]        wb_count
);
  import pgmap_pkg::*;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t             state, state_nx;
  logic [1:0]         wait_cnt;
  logic               read_q;
  logic [VPN_W-1:0]   vpn_q;
  logic [31:0]        entry_q;
  logic               dis_live, acc_n, mod_n, wr_need, invalid_c;

  pgmap_stat_calc u_calc (
    .fc      (cyc_fc),
    .p_back  (p_back),
    .booten  (booten),
    .dis_q   (stat_dis),
    .read    (read_q),
    .valid   (entry_q[PME_VALID]),
    .acc     (entry_q[PME_ACC]),
    .mod     (entry_q[PME_MOD]),
    .dis     (dis_live),
    .acc_n   (acc_n),
    .mod_n   (mod_n),
    .wr_need (wr_need),
    .invalid (invalid_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    ram.pme_re    = 1'b0;
    ram.pme_we    = 1'b0;
    ram.pme_addr  = vpn_q;
    ram.pme_wdata = '0;
    cyc_done      = 1'b0;
    pme_invalid   = 1'b0;
    case (state)
      ST_IDLE:   if (cyc_start) state_nx = ST_LOOKUP;
      ST_LOOKUP: begin
        ram.pme_re = 1'b1;
        state_nx   = ST_WAIT;
      end
      ST_WAIT:   if (wait_cnt == WAIT_LAST) state_nx = ST_CHECK;
      ST_CHECK: begin
        pme_invalid = invalid_c;
        state_nx    = wr_need ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        pme_invalid   = invalid_c;
        ram.pme_we    = 1'b1;
        // stat_acc/stat_mod already hold the updated bits here
        ram.pme_wdata = {entry_q[PME_VALID:PME_TYPE_LO], stat_acc, stat_mod,
                         entry_q[PME_PFN_HI:0]};
        state_nx      = ST_DONE;
      end
      ST_DONE: begin
        pme_invalid = invalid_c;
        cyc_done    = 1'b1;
        if (!cyc_start) state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      read_q    <= 1'b0;
      vpn_q     <= '0;
      entry_q   <= '0;
      stat_dis  <= 1'b0;
      stat_type <= '0;
      stat_acc  <= 1'b0;
      stat_mod  <= 1'b0;
      wb_count  <= '0;
    end else begin
      if (state == ST_IDLE && cyc_start) begin
        read_q   <= cyc_read;
        vpn_q    <= cyc_vpn;
        stat_dis <= dis_live;
      end
      if (state == ST_LOOKUP)    wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (state == ST_WAIT && wait_cnt == WAIT_LAST) entry_q <= ram.pme_rdata;
      if (state == ST_CHECK) begin
        stat_type <= entry_q[PME_TYPE_HI:PME_TYPE_LO];
        stat_acc  <= acc_n;
        stat_mod  <= mod_n;
      end
      if (state == ST_WRITE && wb_count != '1) wb_count <= wb_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/pgmap_stat_writeback.md
Name: pgmap_stat_writeback

Overview:
- Sequencer that updates page-map statistics on every CPU/DMA bus cycle translated by the MMU.
- Steps per cycle: reads the addressed page-map entry (PME) and evaluates the statistics-disable condition. It then sets accessed/modified and writes the entry back to page-map RAM only when the bits change.
- Sits between the CPU cycle-state logic (cycle start strobe) and the synchronous page-map RAM.
- Downstream consumers: the statistic-bit and protection logic, via the latched entry fields and fault flag.

Parameters:
- VPN_W, 11, width of the page-map index (virtual page number).
- RD_LAT, 1, page-map RAM read latency in clocks. Legal range 1..3.
- CNT_W, 16, width of the saturating write-back counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cyc_start  in  1  level; high while a translated bus cycle is in progress.
- cyc_read  in  1  1 = read cycle, 0 = write cycle.
- cyc_fc  in  3  68010 function code.
- cyc_vpn  in  VPN_W  page-map index.
- p_back  in  1  bus granted to refresh/DMA.
- booten  in  1  boot mode; statistics disabled.
- pme_re  out  1  page-map read strobe.
- pme_we  out  1  page-map write strobe.
- pme_addr  out  VPN_W  page-map address.
- pme_rdata  in  32  read data.
- pme_wdata  out  32  write data.
- cyc_done  out  1  sequence complete; CPU cycle may terminate.
- pme_invalid  out  1  entry valid bit was 0 on a non-disabled cycle.
- stat_dis  out  1  registered disable for the current cycle.
- stat_type  out  2  latched type field.
- stat_acc  out  1  latched accessed bit.
- stat_mod  out  1  latched modified bit.
- wb_count  out  CNT_W  saturating count of write-backs.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; wb_count 0. Reset mid-sequence drops pme_we/pme_re immediately and abandons the write.
- PME layout:
  - [31] valid
  - [30:25] prot
  - [24] reserved, written back unchanged
  - [23:22] type
  - [21] acc
  - [20] mod
  - [19:0] pfn
- Capture edge: in IDLE, the edge sampling cyc_start=1 latches cyc_read, cyc_fc, cyc_vpn, p_back and booten. Later changes to these inputs are ignored until the next IDLE.
- Disable condition: dis = (fc[0]&fc[1]&~p_back) | (fc[1]&p_back) | booten. This covers CPU-space/MMU references, refresh, and boot. It is registered as stat_dis at the capture edge.
- State sequence:
  - IDLE -> LOOKUP
  - LOOKUP: pme_re=1 for one cycle; pme_addr = latched vpn and is held until IDLE.
  - WAIT: RD_LAT cycles; pme_rdata is captured at the final edge.
  - CHECK: one cycle; computes new bits.
  - WRITE (optional), then DONE.
- New bits:
  - acc' = acc | (valid & ~dis)
  - mod' = mod | (valid & ~dis & ~read)
- WRITE is entered only if (acc',mod') != (acc,mod). WRITE drives pme_we=1 for one cycle, pme_wdata = the captured entry with acc'/mod' substituted, and increments wb_count (saturates at all-ones).
- pme_invalid = ~valid & ~dis, valid from CHECK until IDLE. An invalid entry is never written.
- stat_type/acc/mod: take post-update values from the CHECK->next edge; held until the next capture.
- DONE: cyc_done=1; the block leaves to IDLE on the first edge with cyc_start=0.
  - If cyc_start is already 0 on DONE entry, DONE lasts one cycle.
  - A new cycle requires cyc_start low in IDLE first; no re-trigger from DONE.
- Abort: cyc_start falling before DONE does not cancel the sequence. A committed read/write completes so the RAM is never left partially updated.
- Latency (RD_LAT=1): cyc_done rises 3 edges after capture without write-back, 4 edges with write-back. In general the counts are 2+RD_LAT and 3+RD_LAT.
- pme_re and pme_we are never high together.

Decomposition:
- Shared package pgmap_pkg:
  - PME field bit positions and widths
  - state enum (IDLE, LOOKUP, WAIT, CHECK, WRITE, DONE)
  - function code constants
  - dis function
- Sub-module pgmap_stat_calc: purely combinational dis/acc'/mod'/write-needed computation. It is reused by the statistic-bit logic model in the bench.
- The remainder is one module.

Test Plan:
- User data read: fc=001, read=1, entry 0x8000_0005 -> pme_we pulse with wdata 0x8020_0005; cyc_done at edge 4; wb_count=1.
- User data write to an already-accessed page: entry 0x8020_0005, read=0 -> wdata 0x8030_0005; a repeat write gives no pme_we, cyc_done at edge 3, wb_count unchanged.
- Disable cases, entry 0x8000_0000 each time: fc=111 p_back=0; fc=010 p_back=1; booten=1 -> stat_dis=1, no write, pme_invalid=0.
- Invalid entry 0x0000_0000, fc=101 -> pme_invalid=1, no pme_we, cyc_done asserted.
- cyc_start dropped 1 clock after capture on a write cycle -> write still issued, DONE lasts one cycle, back in IDLE.
- reset_n low during WRITE -> pme_we=0 asynchronously, outputs 0, wb_count 0. Also: 2^CNT_W+3 write-backs leave wb_count at 0xFFFF.
